// File: rtl/logic_op_issue_pkg.sv
// logic_op_issue_pkg: op/select encodings and request decode shared by the issue stage and its bench
package logic_op_issue_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_XOR = 2'b10
    } sel_e;

    typedef struct packed {
        sel_e sel;
        logic ones;
    } dec_t;

    // NOT a is realised on the XOR path as a ^ 1111
    function automatic dec_t decode(op_e op);
        dec_t d;
        d.sel  = op == OP_AND ? SEL_AND : op == OP_OR ? SEL_OR : SEL_XOR;
        d.ones = op == OP_NOT;
        return d;
    endfunction

endpackage

// File: rtl/logic_op_issue_if.sv
// logic_op_issue_if: request, logic-unit and result handshakes of the issue stage
interface logic_op_issue_if #(
    parameter int W     = 4,
    parameter int TAG_W = 2,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_acc;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic [W-1:0]     lu_a;
    logic [W-1:0]     lu_b;
    logic [1:0]       lu_sel;
    logic [W-1:0]     lu_res;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_op, in_acc, in_a, in_b, in_tag, lu_res, out_ready,
        output in_ready, lu_a, lu_b, lu_sel, out_valid, out_res, out_zero, out_tag, op_count
    );

    modport master (
        output in_valid, in_op, in_acc, in_a, in_b, in_tag, lu_res, out_ready,
        input  in_ready, lu_a, lu_b, lu_sel, out_valid, out_res, out_zero, out_tag, op_count
    );
endinterface

// File: rtl/logic_op_issue.sv
// logic_op_issue: two-register issue/retire stage around the combinational logic unit,
// with accumulate forwarding and a retired-operation counter.
module logic_op_issue
    import logic_op_issue_pkg::*;
#(
    parameter int W     = 4,
    parameter int TAG_W = 2,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    logic_op_issue_if.slave bus
);
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_a_d;
    logic [W-1:0]     s1_b_q, s1_b_d;
    sel_e             s1_sel_q, s1_sel_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_res_q, out_res_d;
    logic             out_zero_q, out_zero_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_adv, retire, accept;
    dec_t             dec;
    logic [W-1:0]     a_eff;

    assign s1_adv = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign retire = out_valid_q && bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !s1_valid_q || s1_adv;
    assign bus.lu_a      = s1_a_q;
    assign bus.lu_b      = s1_b_q;
    assign bus.lu_sel    = s1_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.op_count  = cnt_q;

    // An accept with S1 full implies S1 is advancing, so lu_res is the result being retired into S2
    always_comb begin
        dec         = decode(op_e'(bus.in_op));
        a_eff       = !bus.in_acc ? bus.in_a : s1_valid_q ? bus.lu_res : acc_q;
        s1_valid_d  = accept || (s1_valid_q && !s1_adv);
        s1_a_d      = accept ? a_eff : s1_a_q;
        s1_b_d      = accept ? (dec.ones ? {W{1'b1}} : bus.in_b) : s1_b_q;
        s1_sel_d    = accept ? dec.sel : s1_sel_q;
        s1_tag_d    = accept ? bus.in_tag : s1_tag_q;
        out_valid_d = s1_adv || (out_valid_q && !bus.out_ready);
        out_res_d   = s1_adv ? bus.lu_res : out_res_q;
        out_zero_d  = s1_adv ? (bus.lu_res == '0) : out_zero_q;
        out_tag_d   = s1_adv ? s1_tag_q : out_tag_q;
        acc_d       = s1_adv ? bus.lu_res : acc_q;
        cnt_d       = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sel_q    <= SEL_AND;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_zero_q  <= 1'b1;
            out_tag_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sel_q    <= s1_sel_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            out_tag_q   <= out_tag_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: doc/logic_op_issue.md
Name: logic_op_issue

Overview:
- Issue/retire stage for the combinational 4-bit AND/OR/XOR logic unit in the single-cycle processor datapath.
- Accepts operation requests over a valid/ready handshake and registers the operands and mux select that drive the logic unit.
- Captures the unit's result into an output register with a zero flag and returns it over a second valid/ready handshake.
- Supports accumulate-forwarding and a retired-operation counter. Throughput is 1 op/cycle.

Parameters:
W, 4, data width; must equal the logic unit width
TAG_W, 2, request tag width, carried to the result unchanged
CNT_W, 8, retired-operation counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOT a
in_acc  in  1  1: operand a replaced by forwarded previous result
in_a  in  W  operand a
in_b  in  W  operand b (ignored for NOT)
in_tag  in  TAG_W  request tag
lu_a  out  W  to logic unit operand a
lu_b  out  W  to logic unit operand b
lu_sel  out  2  to logic unit select: 00 AND, 01 OR, 1x XOR
lu_res  in  W  from logic unit, combinational result
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_res  out  W  registered result
out_zero  out  1  1 when out_res == 0
out_tag  out  TAG_W  tag of the result
op_count  out  CNT_W  number of retired results (out_valid && out_ready)

Behaviour:
- Reset: clk, synchronous active-low rst_n, sampled on the rising edge only.
  - While rst_n=0 at an edge, clear s1_valid, out_valid, out_res, out_zero→1, out_tag, acc_q, op_count; S1 a/b/sel/tag → 0, so lu_sel=00.
  - Reset mid-operation discards in-flight S1 and S2 contents with no partial retire.
- S1 (issue register): s1_valid, s1_a, s1_b, s1_sel, s1_tag. lu_a/lu_b/lu_sel are driven directly from the S1 registers, with no combinational path from in_* to lu_*.
- Advance and accept:
  - s1_adv = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s1_adv, combinational; no dependency on in_valid.
- Op decode at accept:
  - AND → sel 00, b = in_b
  - OR → sel 01, b = in_b
  - XOR → sel 10, b = in_b
  - NOT → sel 10, b = all-ones
- Forwarding, when in_acc=1:
  - a_eff = lu_res if s1_valid (S1 must be advancing that cycle, since it is accepting);
  - otherwise a_eff = acc_q.
  - in_acc=0: a_eff = in_a.
- S1 update per edge:
  - If accept: load a_eff/b/sel/tag and set s1_valid=1.
  - Else if s1_adv: s1_valid=0 (data registers hold).
  - Else: hold.
- S2 (output register):
  - On s1_adv: out_res ← lu_res, out_zero ← (lu_res==0), out_tag ← s1_tag, out_valid ← 1, acc_q ← lu_res.
  - Else if out_valid && out_ready: out_valid ← 0.
  - Otherwise hold. out_res/out_tag are stable while out_valid && !out_ready.
- Latency: request accepted at edge N → out_valid=1 after edge N+1. Back-to-back accepts give one result per cycle.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0; nothing is lost or duplicated.
  - Simultaneous retire and capture in the same edge is legal and keeps out_valid=1.
- op_count increments by 1 on each out_valid && out_ready edge and wraps modulo 2^CNT_W (all-ones+1 → 0).
- No state machine beyond the two valid bits. Combined occupancy states: EMPTY(00), S1(10), S2(01), FULL(11) as (s1_valid, out_valid); transitions follow the rules above only.

Decomposition:
- Shared package holds:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11;
  - sel encodings SEL_AND=2'b00, SEL_OR=2'b01, SEL_XOR=2'b10;
  - the decode function op→{sel, force_b_ones}.
- No sub-module inside this block. The logic unit is instantiated beside it at the datapath level and connected via lu_*.
- The verification bench instantiates both together.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, with in_valid=1 at the same time → in_ready=1, out_valid=0, out_zero=1, op_count=0, lu_sel=00. No accept occurs while in reset.
- Basic ops, out_ready=1, one request per cycle:
  - AND a=1100 b=1010 → 1000
  - OR → 1110
  - XOR → 0110
  - NOT a=1100 → 0011
  - Each result one cycle after accept, tags 0..3 in order, op_count=4.
- Forwarding: XOR a=1111 b=0101 (→1010), then immediately AND in_acc=1 b=0110 → second result 0010. After an idle gap, OR in_acc=1 b=0001 → 0011 (from acc_q). Zero flag check: XOR a=b=0110 → out_res=0000, out_zero=1.
- Backpressure: out_ready=0, issue 3 requests → 2 accepted, then in_ready=0. Release out_ready → results retire in order with no loss or duplication, and the third request is then accepted.
- Counter wrap: CNT_W=2, retire 5 results → op_count sequence 1,2,3,0,1.
- Reset mid-operation: FULL state with out_ready=0, assert rst_n=0 for one edge → both valids 0, acc_q=0. Next request with in_acc=1, OR b=0101 → 0101.
